// File: rtl/fifo_pkg.sv
// Shared geometry helpers for the wide-to-narrow FIFO: lane count, index width, parameter sanity.
package fifo_pkg;

    function automatic int lanes(input int wi, input int wo);
        return wi / wo;
    endfunction

    // Minimum width of an index into n items; never less than 1 bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic bit geometry_ok(input int wi, input int wo);
        return (wo > 0) && (wi % wo == 0) && (wi / wo >= 2);
    endfunction

    localparam int DEF_LANE_W = clog2(lanes(128, 32));

endpackage

// File: rtl/fifo_sync_mem.sv
// Single-clock DEPTH x WI word store with wrap-bit pointers; pushes while full are ignored.
module fifo_sync_mem #(
    parameter int WI = 128,
    parameter int WA = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [WI-1:0] din,
    output logic [WI-1:0] head,
    output logic          full,
    output logic [WA:0]   level
);
    localparam int DEPTH = 2 ** WA;

    logic [WI-1:0] mem_q [DEPTH];
    logic [WA:0]   wptr_q, wptr_d;
    logic [WA:0]   rptr_q, rptr_d;
    logic          push_ok, pop_ok;

    assign level   = wptr_q - rptr_q;
    assign full    = (wptr_q[WA] != rptr_q[WA]) && (wptr_q[WA-1:0] == rptr_q[WA-1:0]);
    assign head    = mem_q[rptr_q[WA-1:0]];
    assign push_ok = push && !full;
    assign pop_ok  = pop && (level != '0);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: nothing is readable until the pointers move.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wptr_q[WA-1:0]] <= din;
    end

endmodule

// File: rtl/fifo_wide2narrow.sv
// Buffers WI-bit words and presents them WO bits at a time; rd&valid steps the lane and
// reloads from storage on the last lane in the same edge, so consecutive words have no bubble.
module fifo_wide2narrow
    import fifo_pkg::*;
#(
    parameter int WI        = 128,
    parameter int WO        = 32,
    parameter int WA        = 8,
    parameter bit MSB_FIRST = 1'b0,
    parameter int AF_MARGIN = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr,
    input  logic [WI-1:0]                data_in,
    output logic                         full,
    output logic                         almost_full,
    input  logic                         rd,
    output logic [WO-1:0]                data_out,
    output logic                         valid,
    output logic                         empty,
    output logic [WA:0]                  level,
    output logic [clog2(lanes(WI,WO))-1:0] lane,
    output logic                         ovf,
    output logic                         udf,
    input  logic                         clr_err
);
    localparam int N     = lanes(WI, WO);
    localparam int LW    = clog2(N);
    localparam int DEPTH = 2 ** WA;

    if (!geometry_ok(WI, WO)) begin : g_bad_geometry
        $error("fifo_wide2narrow: WI must be a multiple of WO with at least two lanes");
    end

    logic [WI-1:0]        hold_q, hold_d;
    logic                 hv_q, hv_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;
    logic [WI-1:0]        head;
    logic                 mem_full;
    logic [WA:0]          mem_level;
    logic                 consume, last_lane, pop;
    logic [N-1:0][WO-1:0] lane_words;
    logic [LW-1:0]        sel;

    fifo_sync_mem #(.WI(WI), .WA(WA)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .push  (wr),
        .pop   (pop),
        .din   (data_in),
        .head  (head),
        .full  (mem_full),
        .level (mem_level)
    );

    always_comb begin
        consume   = rd && hv_q;
        last_lane = (lane_q == LW'(N - 1));
        // Fill an idle holder, or refill it on the edge that consumes its last lane.
        pop       = (mem_level != '0) && (!hv_q || (consume && last_lane));
        hold_d    = hold_q;
        hv_d      = hv_q;
        lane_d    = lane_q;
        if (pop) begin
            hold_d = head;
            hv_d   = 1'b1;
            lane_d = '0;
        end else if (consume) begin
            if (last_lane) begin
                hv_d   = 1'b0;
                lane_d = '0;
            end else begin
                lane_d = lane_q + 1'b1;
            end
        end
        // An error in the same cycle as clr_err keeps the flag set.
        ovf_d = (ovf_q && !clr_err) || (wr && mem_full);
        udf_d = (udf_q && !clr_err) || (rd && !hv_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            hv_q   <= 1'b0;
            lane_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            hv_q   <= hv_d;
            lane_q <= lane_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    assign lane_words  = hold_q;
    assign sel         = MSB_FIRST ? (LW'(N - 1) - lane_q) : lane_q;
    assign data_out    = lane_words[sel];
    assign valid       = hv_q;
    assign empty       = !hv_q;
    assign lane        = lane_q;
    assign level       = mem_level;
    assign full        = mem_full;
    assign almost_full = (mem_level >= (WA + 1)'(DEPTH - AF_MARGIN));
    assign ovf         = ovf_q;
    assign udf         = udf_q;

endmodule

// File: tb/tb_fifo_wide2narrow.sv
// Directed tests for fifo_wide2narrow; the first word written always parks in the holder, so it is not counted in level.
module tb_fifo_wide2narrow;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr = 1'b0;
    logic [127:0] data_in = '0;
    logic         rd = 1'b0;
    logic         clr_err = 1'b0;

    logic         full, almost_full, valid, empty, ovf, udf;
    logic [31:0]  data_out;
    logic [8:0]   level;
    logic [1:0]   lane;

    logic         m_full, m_almost_full, m_valid, m_empty, m_ovf, m_udf;
    logic [31:0]  m_data_out;
    logic [8:0]   m_level;
    logic [1:0]   m_lane;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_wide2narrow #(.WI(128), .WO(32), .WA(8), .MSB_FIRST(1'b0), .AF_MARGIN(4)) u_dut (
        .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .full(full),
        .almost_full(almost_full), .rd(rd), .data_out(data_out), .valid(valid),
        .empty(empty), .level(level), .lane(lane), .ovf(ovf), .udf(udf), .clr_err(clr_err)
    );

    fifo_wide2narrow #(.WI(128), .WO(32), .WA(8), .MSB_FIRST(1'b1), .AF_MARGIN(4)) u_dut_msb (
        .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .full(m_full),
        .almost_full(m_almost_full), .rd(rd), .data_out(m_data_out), .valid(m_valid),
        .empty(m_empty), .level(m_level), .lane(m_lane), .ovf(m_ovf), .udf(m_udf), .clr_err(clr_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word w carries lane values 4w, 4w+1, 4w+2, 4w+3 from lane 0 upward.
    function automatic logic [127:0] wd(input int w);
        return {32'(4*w+3), 32'(4*w+2), 32'(4*w+1), 32'(4*w)};
    endfunction

    task automatic do_reset();
        wr = 0; rd = 0; clr_err = 0; rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b%b exp=00", full, almost_full); end
        checks++; if (level !== 9'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (data_out !== 32'h0 || lane !== 2'd0) begin failures++; $display("FAIL reset_data got=%h/%0d exp=0/0", data_out, lane); end
        checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", ovf, udf); end
    endtask

    task automatic test_latency();
        do_reset();
        wr = 1; data_in = 128'h33333333_22222222_11111111_00000000;
        tick();
        wr = 0;
        checks++; if (valid !== 1'b0 || level !== 9'd1) begin failures++; $display("FAIL lat_edge1 got=v%b l%0d exp=v0 l1", valid, level); end
        tick();
        checks++; if (valid !== 1'b1 || level !== 9'd0) begin failures++; $display("FAIL lat_edge2 got=v%b l%0d exp=v1 l0", valid, level); end
        checks++; if (data_out !== 32'h00000000 || lane !== 2'd0) begin failures++; $display("FAIL lat_data got=%h/%0d exp=00000000/0", data_out, lane); end
        checks++; if (m_data_out !== 32'h33333333) begin failures++; $display("FAIL lat_msb_first got=%h exp=33333333", m_data_out); end
        rd = 1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (m_data_out !== 32'(3 - i) * 32'h11111111) begin failures++; $display("FAIL msb_lane%0d got=%h exp=%h", i, m_data_out, 32'(3 - i) * 32'h11111111); end
            tick();
        end
        rd = 0;
        checks++; if (valid !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL lat_drain got=v%b e%b exp=v0 e1", valid, empty); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wr = 1; data_in = 128'h33333333_22222222_11111111_00000000;
        tick();
        data_in = 128'h77777777_66666666_55555555_44444444;
        tick();
        wr = 0; rd = 1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (valid !== 1'b1 || data_out !== 32'(i) * 32'h11111111) begin failures++; $display("FAIL b2b_lane%0d got=v%b %h exp=v1 %h", i, valid, data_out, 32'(i) * 32'h11111111); end
            tick();
        end
        rd = 0;
        checks++; if (valid !== 1'b0 || level !== 9'd0) begin failures++; $display("FAIL b2b_end got=v%b l%0d exp=v0 l0", valid, level); end
    endtask

    task automatic test_fill();
        do_reset();
        wr = 1;
        for (int k = 1; k <= 257; k++) begin
            data_in = wd(k - 1);
            tick();
            // Word 0 moves to the holder at the second edge, so storage holds k-1 words.
            if (k == 252) begin
                checks++; if (almost_full !== 1'b0 || level !== 9'd251) begin failures++; $display("FAIL fill_252 got=af%b l%0d exp=af0 l251", almost_full, level); end
            end
            if (k == 253) begin
                checks++; if (almost_full !== 1'b1 || level !== 9'd252) begin failures++; $display("FAIL fill_253 got=af%b l%0d exp=af1 l252", almost_full, level); end
            end
            if (k == 256) begin
                checks++; if (full !== 1'b0) begin failures++; $display("FAIL fill_256 got=full%b exp=0", full); end
            end
        end
        checks++; if (full !== 1'b1 || level !== 9'd256 || ovf !== 1'b0) begin failures++; $display("FAIL fill_full got=f%b l%0d o%b exp=f1 l256 o0", full, level, ovf); end
        data_in = wd(999);
        tick();
        wr = 0;
        checks++; if (ovf !== 1'b1 || level !== 9'd256) begin failures++; $display("FAIL fill_ovf got=o%b l%0d exp=o1 l256", ovf, level); end
        checks++; if (valid !== 1'b1 || data_out !== 32'd0) begin failures++; $display("FAIL fill_head got=v%b %h exp=v1 0", valid, data_out); end
    endtask

    task automatic test_underflow();
        do_reset();
        rd = 1;
        tick();
        rd = 0;
        checks++; if (udf !== 1'b1 || valid !== 1'b0 || level !== 9'd0 || ovf !== 1'b0) begin failures++; $display("FAIL udf_set got=u%b v%b l%0d o%b exp=u1 v0 l0 o0", udf, valid, level, ovf); end
        clr_err = 1;
        tick();
        checks++; if (udf !== 1'b0) begin failures++; $display("FAIL udf_clear got=%b exp=0", udf); end
        rd = 1;
        tick();
        rd = 0; clr_err = 0;
        checks++; if (udf !== 1'b1) begin failures++; $display("FAIL udf_wins got=%b exp=1", udf); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        wr = 1;
        for (int w = 0; w < 11; w++) begin
            data_in = wd(w);
            tick();
        end
        wr = 0; rd = 1;
        tick(); tick(); tick();
        checks++; if (level !== 9'd10 || lane !== 2'd3 || data_out !== 32'd3) begin failures++; $display("FAIL sim_pre got=l%0d ln%0d %h exp=l10 ln3 3", level, lane, data_out); end
        wr = 1; data_in = wd(11);
        tick();
        wr = 0; rd = 0;
        checks++; if (level !== 9'd10 || lane !== 2'd0) begin failures++; $display("FAIL sim_level got=l%0d ln%0d exp=l10 ln0", level, lane); end
        checks++; if (valid !== 1'b1 || data_out !== 32'd4) begin failures++; $display("FAIL sim_next got=v%b %h exp=v1 4", valid, data_out); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rd = 1;
        tick();
        rd = 0;
        wr = 1;
        for (int w = 0; w < 6; w++) begin
            data_in = wd(w);
            tick();
        end
        wr = 0; rd = 1;
        tick(); tick();
        rd = 0;
        checks++; if (level !== 9'd5 || lane !== 2'd2 || udf !== 1'b1) begin failures++; $display("FAIL mid_pre got=l%0d ln%0d u%b exp=l5 ln2 u1", level, lane, udf); end
        rst = 1; wr = 1; rd = 1; data_in = wd(50);
        tick();
        rst = 0; wr = 0; rd = 0;
        checks++; if (valid !== 1'b0 || level !== 9'd0 || data_out !== 32'h0 || lane !== 2'd0) begin failures++; $display("FAIL mid_state got=v%b l%0d %h ln%0d exp=v0 l0 0 ln0", valid, level, data_out, lane); end
        checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin failures++; $display("FAIL mid_flags got=%b%b exp=00", ovf, udf); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_fill();
        test_underflow();
        test_simultaneous();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
